capture_reader: RTL and testbench

Downstream readout stage of the DSO capture path. When the ADC capture driver reports a completed capture (`valid`), this block takes the trigger address, walks the circular sample buffer in chronological order starting `PRE_TRIG` samples before the trigger, and streams each 16-bit sample as two bytes over a valid/ready byte interface to the SPI module. It holds `cap_ready` low for the whole readout, so the capture driver cannot re-arm until the host has drained the buffer.

---
 rtl/dso_pkg.sv | 32 +++
 rtl/capture_reader_word_to_bytes.sv | 41 ++++
 rtl/capture_reader.sv | 164 ++++++++++++++++
 tb/tb_capture_reader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dso_pkg.sv
// Shared definitions for the DSO capture readout path.
// State encoding depends on CAPTURE_READER_HEADER_EN: the header states
// HDR0/HDR1 exist only when that macro is defined.
package dso_pkg;

    // Sync byte that opens every frame when the header is enabled
    localparam logic [7:0] HDR_SYNC = 8'hA5;

    // Sample buffer read latency in cycles (rd_en -> rd_data)
    localparam int RD_LAT = 1;

`ifdef CAPTURE_READER_HEADER_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_RD   = 3'd3,
        S_WT   = 3'd4,
        S_HI   = 3'd5,
        S_LO   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd3,
        S_WT   = 3'd4,
        S_HI   = 3'd5,
        S_LO   = 3'd6
    } state_t;
`endif

endpackage

// File: rtl/capture_reader_word_to_bytes.sv
// word_to_bytes: holds one 16-bit buffer word and presents it as two bytes
// (high then low) on a valid/ready byte port. The phase (HI/LO) comes from
// the owning FSM; this block supplies the word register and byte steering.
module word_to_bytes (
    input  logic        clk,
    input  logic        load,
    input  logic [15:0] in_data,
    input  logic        sel_hi,
    input  logic        sel_lo,
    input  logic        last_in,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic        byte_done
);

    logic [15:0] word;

    // Capture the buffer word; held unchanged through both byte phases and any stall
    always_ff @(posedge clk) begin
        if (load) begin
            word <= in_data;
        end
    end

    // Steer the selected half of the word to the byte port; zero when idle
    always_comb begin
        out_data = 8'h00;
        if (sel_hi) begin
            out_data = word[15:8];
        end else if (sel_lo) begin
            out_data = word[7:0];
        end
    end

    assign out_valid = sel_hi | sel_lo;
    assign out_last  = sel_lo & last_in;
    assign byte_done = out_valid & out_ready;

endmodule

// File: rtl/capture_reader.sv
// capture_reader: after a completed capture, walks the circular sample
// buffer from PRE_TRIG samples before the trigger and streams each 16-bit
// sample as two bytes (MSB first). cap_ready stays low until the whole
// frame has drained. Define CAPTURE_READER_HEADER_EN to prefix each frame
// with a sync byte and the trigger address.
module capture_reader
    import dso_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PRE_TRIG = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_valid,
    output logic             cap_ready,
    input  logic [DEPTH:0]   trig_addr,
    output logic             rd_en,
    output logic [DEPTH:0]   rd_addr,
    input  logic [15:0]      rd_data,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int AW = DEPTH + 1;
    localparam int N  = 2 ** AW;
    localparam logic [AW-1:0] PRE_OFF  = AW'(PRE_TRIG);
    localparam logic [AW-1:0] CNT_LAST = AW'(N - 1);

    // Elaboration-time parameter checks
    if (PRE_TRIG < 0 || PRE_TRIG > N - 1) begin : g_chk_pretrig
        $error("capture_reader: PRE_TRIG must be in 0..N-1");
    end
    if (RD_LAT != 1) begin : g_chk_rdlat
        $error("capture_reader: FSM assumes a single WT cycle of read latency");
    end
`ifdef CAPTURE_READER_HEADER_EN
    if (AW > 8) begin : g_chk_hdr
        $error("capture_reader: trigger address does not fit the header byte");
    end
`endif

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   start;
    logic [AW-1:0]   cnt;
    logic            handshake;
    logic            ser_load;
    logic            ser_hi;
    logic            ser_lo;
    logic            ser_last_in;
    logic [7:0]      ser_data;
    logic            ser_valid;
    logic            ser_last;
    logic            ser_done;
`ifdef CAPTURE_READER_HEADER_EN
    logic [AW-1:0]   taddr;
`endif

    assign handshake   = (state == S_IDLE) & cap_valid;
    assign ser_load    = (state == S_WT);
    assign ser_hi      = (state == S_HI);
    assign ser_lo      = (state == S_LO);
    assign ser_last_in = (cnt == CNT_LAST);

    word_to_bytes u_ser (
        .clk       (clk),
        .load      (ser_load),
        .in_data   (rd_data),
        .sel_hi    (ser_hi),
        .sel_lo    (ser_lo),
        .last_in   (ser_last_in),
        .out_ready (out_ready),
        .out_data  (ser_data),
        .out_valid (ser_valid),
        .out_last  (ser_last),
        .byte_done (ser_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Word counter: cleared on accept, advances when a non-final low byte is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (handshake) begin
            cnt <= '0;
        end else if (ser_lo && ser_done && (cnt != CNT_LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Latch frame start (and trigger address) at the capture handshake only
    always_ff @(posedge clk) begin
        if (handshake) begin
            start <= trig_addr - PRE_OFF;
`ifdef CAPTURE_READER_HEADER_EN
            taddr <= trig_addr;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cap_valid) begin
`ifdef CAPTURE_READER_HEADER_EN
                    state_nxt = S_HDR0;
`else
                    state_nxt = S_RD;
`endif
                end
            end
`ifdef CAPTURE_READER_HEADER_EN
            S_HDR0:  if (out_ready) state_nxt = S_HDR1;
            S_HDR1:  if (out_ready) state_nxt = S_RD;
`endif
            S_RD:    state_nxt = S_WT;
            S_WT:    state_nxt = S_HI;
            S_HI:    if (ser_done) state_nxt = S_LO;
            S_LO: begin
                if (ser_done) begin
                    state_nxt = (cnt == CNT_LAST) ? S_IDLE : S_RD;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the state register and held data registers
    always_comb begin
        cap_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        rd_en     = (state == S_RD);
        rd_addr   = '0;
        if (state == S_RD) begin
            rd_addr = start + cnt;
        end
        out_valid = ser_valid;
        out_data  = ser_data;
        out_last  = ser_last;
`ifdef CAPTURE_READER_HEADER_EN
        if (state == S_HDR0) begin
            out_valid = 1'b1;
            out_data  = HDR_SYNC;
        end else if (state == S_HDR1) begin
            out_valid = 1'b1;
            out_data  = 8'(taddr);
        end
`endif
    end

endmodule

// File: tb/tb_capture_reader.sv
// Bench for capture_reader with DEPTH=2 (N=8), PRE_TRIG=2, buffer word i =
// 16'h1000+i. Expected bytes are queued at stimulus time and popped by an
// independent monitor. Honours CAPTURE_READER_HEADER_EN when defined.
module tb_capture_reader;

    localparam int DEPTH    = 2;
    localparam int PRE_TRIG = 2;
    localparam int N        = 8;

`ifdef CAPTURE_READER_HEADER_EN
    localparam int FRAME_LAT = 4 * N + 3;
`else
    localparam int FRAME_LAT = 4 * N + 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cap_valid;
    logic        cap_ready;
    logic [2:0]  trig_addr;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          bytes_seen = 0;
    logic [8:0]  exp_q[$];
    bit          bp = 1'b0;
    int          cyc = 0;
    bit          pstall = 1'b0;
    logic [7:0]  pdata;
    logic        plast;
    logic [8:0]  e;
    int          lat;
    int          base;
    int          guard;

    always #5 clk = ~clk;

    capture_reader #(.DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG)) dut (
        .clk       (clk),
        .rst       (rst),
        .cap_valid (cap_valid),
        .cap_ready (cap_ready),
        .trig_addr (trig_addr),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    // Sample buffer model: one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) rd_data <= 16'h1000 + {13'd0, rd_addr};
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream readiness: always ready, or one cycle in three under backpressure
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            out_ready = bp ? (cyc % 3 == 0) : 1'b1;
        end
    end

    // Monitor: stall stability and in-order byte comparison against the queue
    initial begin
        forever begin
            @(negedge clk);
            if (pstall) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_data", int'(out_data), int'(pdata));
                chk("stall_last", int'(out_last), int'(plast));
            end
            pstall = (out_valid === 1'b1) && (out_ready === 1'b0);
            pdata  = out_data;
            plast  = out_last;
            if ((out_valid === 1'b1) && (out_ready === 1'b1)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h with no byte expected", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte", int'(out_data), int'(e[7:0]));
                    chk("last", int'(out_last), int'(e[8]));
                    bytes_seen++;
                end
            end
        end
    end

    // Queue the hand-derived byte sequence for a frame triggered at ta
    task automatic push_frame(input logic [2:0] ta);
        logic [2:0] s;
        logic [2:0] a;
        s = ta - 3'(PRE_TRIG);
`ifdef CAPTURE_READER_HEADER_EN
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, 5'd0, ta});
`endif
        for (int i = 0; i < N; i++) begin
            a = s + 3'(i);
            exp_q.push_back({1'b0, 8'h10});
            exp_q.push_back({(i == N - 1), 5'd0, a});
        end
    endtask

    // Issue a capture handshake; returns at cycle T+3 with n = 3
    task automatic start_frame(input logic [2:0] ta, input bit hold, output int n);
        logic [2:0] s;
        s = ta - 3'(PRE_TRIG);
        chk("cap_ready_before", int'(cap_ready), 1);
        trig_addr = ta;
        cap_valid = 1'b1;
        push_frame(ta);
        @(posedge clk); #1;
        if (!hold) cap_valid = 1'b0;
        trig_addr = ~ta;
        chk("cap_ready_T1", int'(cap_ready), 0);
        chk("busy_T1", int'(busy), 1);
`ifdef CAPTURE_READER_HEADER_EN
        chk("out_valid_T1", int'(out_valid), 1);
        chk("rd_en_T1", int'(rd_en), 0);
`else
        chk("rd_en_T1", int'(rd_en), 1);
        chk("rd_addr_T1", int'(rd_addr), int'(s));
        chk("out_valid_T1", int'(out_valid), 0);
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
`ifndef CAPTURE_READER_HEADER_EN
        chk("out_valid_T3", int'(out_valid), 1);
`endif
        n = 3;
    endtask

    // Wait (bounded) for cap_ready; optionally check the exact cycle it rises
    task automatic wait_idle(input int n0, input int exp_lat, input string name);
        int n;
        n = n0;
        while (cap_ready !== 1'b1 && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_lat > 0) chk(name, n, exp_lat);
        else chk(name, int'(cap_ready), 1);
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        rst       = 1'b1;
        cap_valid = 1'b0;
        trig_addr = 3'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_cap_ready", int'(cap_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_data", int'(out_data), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic frame, trigger at 5
        start_frame(3'd5, 1'b0, lat);
        wait_idle(lat, FRAME_LAT, "basic_lat");

        // Start address wraps: trigger at 0 -> start at 6
        start_frame(3'd0, 1'b0, lat);
        wait_idle(lat, FRAME_LAT, "wrap_lat");

        // Backpressure
        bp = 1'b1;
        start_frame(3'd5, 1'b0, lat);
        wait_idle(lat, -1, "bp_done");
        bp = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // cap_valid held through the frame: one frame, then a new one at idle
        start_frame(3'd5, 1'b1, lat);
        wait_idle(lat, FRAME_LAT, "hold_lat");
        start_frame(3'd0, 1'b0, lat);
        wait_idle(lat, FRAME_LAT, "hold2_lat");

        // Reset after the 5th byte, then a clean full frame
        base = bytes_seen;
        start_frame(3'd5, 1'b0, lat);
        guard = 0;
        while (bytes_seen < base + 5 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("rst_mid_reached", int'(bytes_seen >= base + 5), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_cap_ready", int'(cap_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_out_last", int'(out_last), 0);
        chk("midrst_rd_en", int'(rd_en), 0);
        exp_q.delete();
        @(posedge clk); #1;
        chk("midrst_quiet", int'(out_valid), 0);
        start_frame(3'd5, 1'b0, lat);
        wait_idle(lat, FRAME_LAT, "post_rst_lat");

        // Trigger at 1 -> start wraps to 7
        start_frame(3'd1, 1'b0, lat);
        wait_idle(lat, FRAME_LAT, "trig1_lat");

        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("final_drained", exp_q.size(), 0);
        chk("final_idle", int'(cap_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
